// File: rtl/reg_fifo_if_pkg.sv
// rtl/reg_fifo_if_pkg.sv - CSR bit map shared by the register-mapped FIFO port
package reg_fifo_if_pkg;

  localparam int EN_B    = 0;
  localparam int FULL_B  = 1;
  localparam int EMPTY_B = 2;
  localparam int OVF_B   = 3;
  localparam int UDF_B   = 4;
  localparam int CNT_LSB = 8;

  // Write-only strobe bit in a CSR write; it shares position 1 with the full flag on read.
  localparam int CLR_B   = 1;

endpackage

// File: rtl/reg_fifo_if_sync_fifo.sv
// rtl/reg_fifo_if_sync_fifo.sv - single-clock FIFO with occupancy count and synchronous clear
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/reg_fifo_if.sv
// rtl/reg_fifo_if.sv - register-mapped data port: CSR at Reg_sel=0, FIFO data port at Reg_sel=1
module reg_fifo_if
  import reg_fifo_if_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WR,
  input  logic             RD,
  input  logic             Reg_sel,
  input  logic [WIDTH-1:0] Entrada,
  output logic [WIDTH-1:0] Salida
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             en;
  logic             ovf;
  logic             udf;
  logic             csr_wr;
  logic             csr_rd;
  logic             push_req;
  logic             pop_req;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] fifo_dout;
  logic [WIDTH-1:0] status;

  assign csr_wr   = WR & ~Reg_sel;
  assign csr_rd   = RD & ~Reg_sel;
  assign push_req = WR & Reg_sel;
  assign pop_req  = RD & Reg_sel;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req & en),
    .pop   (pop_req),
    .clr   (csr_wr & Entrada[CLR_B]),
    .din   (Entrada),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status                   = '0;
    status[EN_B]             = en;
    status[FULL_B]           = full;
    status[EMPTY_B]          = empty;
    status[OVF_B]            = ovf;
    status[UDF_B]            = udf;
    status[CNT_LSB +: CNT_W] = count;
  end

  // Flag set and clear never collide: set needs Reg_sel=1, clear needs Reg_sel=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en  <= 1'b0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (csr_wr) begin
        en <= Entrada[EN_B];
        if (Entrada[OVF_B]) ovf <= 1'b0;
        if (Entrada[UDF_B]) udf <= 1'b0;
      end
      if (push_req && en && full && !pop_req) ovf <= 1'b1;
      if (pop_req && empty)                   udf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Salida <= '0;
    end else if (pop_req && !empty) begin
      Salida <= fifo_dout;
    end else if (csr_rd) begin
      Salida <= status;
    end
  end

endmodule

// File: tb/tb_reg_fifo_if.sv
// tb/tb_reg_fifo_if.sv - randomized and directed bench for reg_fifo_if against a queue-based model
module tb_reg_fifo_if;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             WR = 1'b0;
  logic             RD = 1'b0;
  logic             Reg_sel = 1'b0;
  logic [WIDTH-1:0] Entrada = '0;
  logic [WIDTH-1:0] Salida;

  reg_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .WR      (WR),
    .RD      (RD),
    .Reg_sel (Reg_sel),
    .Entrada (Entrada),
    .Salida  (Salida)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_en;
  logic             m_ovf;
  logic             m_udf;
  logic [WIDTH-1:0] m_salida;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [WIDTH-1:0] m_status();
    logic [WIDTH-1:0] st;
    st       = '0;
    st[0]    = m_en;
    st[1]    = (q.size() == DEPTH);
    st[2]    = (q.size() == 0);
    st[3]    = m_ovf;
    st[4]    = m_udf;
    st[8+:4] = q.size();
    return st;
  endfunction

  task automatic m_reset();
    q.delete();
    m_en     = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_salida = '0;
  endtask

  // Apply one bus cycle, advance the model by the rules of the port, then compare Salida.
  task automatic op(input string tag, input logic wr, input logic rd, input logic sel,
                    input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] st;
    int               pre;
    logic             popped;
    WR = wr; RD = rd; Reg_sel = sel; Entrada = d;
    @(posedge clk);
    #1;
    WR = 1'b0; RD = 1'b0;
    st     = m_status();
    pre    = q.size();
    popped = 1'b0;
    if (sel) begin
      if (rd) begin
        if (pre > 0) begin
          m_salida = q.pop_front();
          popped   = 1'b1;
        end else begin
          m_udf = 1'b1;
        end
      end
      if (wr && m_en) begin
        if (pre < DEPTH || popped) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end else begin
      if (rd) m_salida = st;
      if (wr) begin
        m_en = d[0];
        if (d[1]) q.delete();
        if (d[3]) m_ovf = 1'b0;
        if (d[4]) m_udf = 1'b0;
      end
    end
    check(tag, Salida, m_salida);
  endtask

  task automatic csr_read(input string tag);
    op(tag, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    m_reset();
    #30 rst = 1'b1;
    check("reset_salida", Salida, '0);
    csr_read("reset_csr");
    check("reset_csr_const", Salida, 32'h4);

    op("en_on", 1'b1, 1'b0, 1'b0, 32'h1);
    op("push1", 1'b1, 1'b0, 1'b1, 32'h1);
    op("push2", 1'b1, 1'b0, 1'b1, 32'h2);
    op("pop1", 1'b0, 1'b1, 1'b1, '0);
    check("order_first", Salida, 32'h1);
    op("pop2", 1'b0, 1'b1, 1'b1, '0);
    check("order_second", Salida, 32'h2);
    csr_read("order_csr");
    check("order_csr_const", Salida, 32'h5);

    for (int i = 0; i < 9; i++) op("ovf_push", 1'b1, 1'b0, 1'b1, i);
    csr_read("ovf_csr");
    check("ovf_csr_const", Salida, 32'h80B);
    for (int i = 0; i < 8; i++) begin
      op("ovf_pop", 1'b0, 1'b1, 1'b1, '0);
      check("ovf_pop_val", Salida, i);
    end
    op("ovf_clr", 1'b1, 1'b0, 1'b0, 32'h9);
    csr_read("ovf_clr_csr");
    check("ovf_clr_const", Salida, 32'h5);

    op("udf_pop", 1'b0, 1'b1, 1'b1, '0);
    check("udf_hold", Salida, 32'h5);
    op("udf_wrrd", 1'b1, 1'b1, 1'b1, 32'hA5);
    csr_read("udf_csr");
    check("udf_csr_const", Salida, 32'h111);
    op("udf_pop_a5", 1'b0, 1'b1, 1'b1, '0);
    check("udf_a5", Salida, 32'hA5);

    for (int i = 0; i < 8; i++) op("full_push", 1'b1, 1'b0, 1'b1, 32'h10 + i);
    op("full_wrrd", 1'b1, 1'b1, 1'b1, 32'hFF);
    check("full_wrrd_val", Salida, 32'h10);
    csr_read("full_csr");
    check("full_csr_const", Salida, 32'h813);
    for (int i = 0; i < 8; i++) op("full_drain", 1'b0, 1'b1, 1'b1, '0);
    check("full_last", Salida, 32'hFF);

    for (int i = 0; i < 3; i++) op("clr_push", 1'b1, 1'b0, 1'b1, 32'h30 + i);
    op("clr_wr", 1'b1, 1'b0, 1'b0, 32'h3);
    csr_read("clr_csr");
    check("clr_csr_const", Salida, 32'h15);

    op("wr_rd_csr", 1'b1, 1'b1, 1'b0, 32'h19);
    check("wr_rd_csr_pre", Salida, 32'h15);
    op("en_off", 1'b1, 1'b0, 1'b0, 32'h0);
    op("push_dis", 1'b1, 1'b0, 1'b1, 32'hDEAD);
    csr_read("dis_csr");
    check("dis_csr_const", Salida, 32'h4);

    for (int i = 0; i < 400; i++) begin
      logic             wr, rd, sel;
      logic [WIDTH-1:0] d;
      wr  = $urandom_range(0, 1);
      rd  = $urandom_range(0, 1);
      sel = ($urandom_range(0, 3) != 0);
      d   = $urandom;
      if (!sel) d[0] = ($urandom_range(0, 7) != 0);
      if (!sel && $urandom_range(0, 7) != 0) d[1] = 1'b0;
      op("rand", wr, rd, sel, d);
    end

    op("mid_en", 1'b1, 1'b0, 1'b0, 32'h1);
    op("mid_push", 1'b1, 1'b0, 1'b1, 32'h77);
    op("mid_push", 1'b1, 1'b0, 1'b1, 32'h78);
    op("mid_pop", 1'b0, 1'b1, 1'b1, '0);
    rst = 1'b0;
    #2;
    m_reset();
    check("mid_rst_async", Salida, '0);
    #2 rst = 1'b1;
    csr_read("mid_rst_csr");
    check("mid_rst_csr_const", Salida, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
